// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between requesters and the locking round-robin arbiter.
// The arbiter drives the grant side; requesters drive req_i and last_i.
interface rr_lock_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_i;
  logic               last_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic               gnt_vld_o;
  logic [ID_W-1:0]    gnt_id_o;
  logic               timeout_o;

  modport master (
    output req_i,
    output last_i,
    input  gnt_o,
    input  gnt_vld_o,
    input  gnt_id_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    input  last_i,
    output gnt_o,
    output gnt_vld_o,
    output gnt_id_o,
    output timeout_o
  );
endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks a registered one-hot grant onto its owner until
// last_i, a dropped request, or the MAX_HOLD timeout releases it.
//
//   state | meaning
//   IDLE  | no grant active, gnt_o is all-zero
//   OWNED | gnt_o holds the one-hot owner, hold counter running
module rr_lock_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 16,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  rr_lock_arbiter_if.slave bus
);

  localparam int                 CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0]   HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [ID_W-1:0]    LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t             state_q, state_n;
  logic [ID_W-1:0]    ptr_q, ptr_n;
  logic [ID_W-1:0]    id_q, id_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic               vld_q;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               tmo_q, tmo_n;

  logic               rel_last;
  logic               rel_drop;
  logic               rel_tmo;
  logic               release_now;
  logic [ID_W-1:0]    ptr_rel;
  logic [ID_W-1:0]    arb_ptr;
  logic               win_found;
  logic [ID_W-1:0]    win_id;

  assign rel_last    = bus.last_i;
  assign rel_drop    = ~bus.req_i[id_q];
  assign rel_tmo     = (MAX_HOLD != 0) && (cnt_q == HOLD_MAX);
  assign release_now = (state_q == OWNED) && (rel_last || rel_drop || rel_tmo);
  assign ptr_rel     = (id_q == LAST_ID) ? '0 : id_q + 1'b1;

  // On release the pointer moves past the owner in the same edge, so the
  // follow-on winner is chosen with the rotated priority and no idle gap.
  assign arb_ptr = release_now ? ptr_rel : ptr_q;

  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(arb_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && bus.req_i[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    id_n    = id_q;
    gnt_n   = gnt_q;
    cnt_n   = cnt_q;
    tmo_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_n = OWNED;
          gnt_n   = ONE_HOT0 << win_id;
          id_n    = win_id;
          cnt_n   = CNT_ONE;
        end
      end
      OWNED: begin
        if (release_now) begin
          ptr_n = ptr_rel;
          // Only a pure expiry counts as a timeout.
          tmo_n = rel_tmo && !rel_last && !rel_drop;
          if (win_found) begin
            gnt_n = ONE_HOT0 << win_id;
            id_n  = win_id;
            cnt_n = CNT_ONE;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            cnt_n   = '0;
          end
        end else if ((MAX_HOLD != 0) && (cnt_q != HOLD_MAX)) begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      id_q    <= id_n;
      gnt_q   <= gnt_n;
      vld_q   <= |gnt_n;
      cnt_q   <= cnt_n;
      tmo_q   <= tmo_n;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_vld_o = vld_q;
  assign bus.gnt_id_o  = id_q;
  assign bus.timeout_o = tmo_q;

endmodule
